// File: rtl/fp_vec_drain_pkg.sv
// fp_vec_drain_pkg: shared fp helpers (element width, NaN/Inf classification) and the IEEE754 struct macro.
`ifndef IEEE754
`define IEEE754(NX, NM) struct packed {logic sign; logic [(NX)-1:0] exp; logic [(NM)-1:0] man;}
`endif
package fp_vec_drain_pkg;
  typedef enum logic {IDLE, DRAIN} state_t;
  function automatic int fp_width(input int nx, input int nm);
    return 1 + nx + nm;
  endfunction
  function automatic logic is_exc(input logic exp_ones);
    return exp_ones;
  endfunction
  function automatic logic is_nan(input logic exp_ones, input logic man_zero);
    return exp_ones & ~man_zero;
  endfunction
  function automatic logic is_inf(input logic exp_ones, input logic man_zero);
    return exp_ones & man_zero;
  endfunction
endpackage

// File: rtl/fp_vec_drain_classify.sv
// fp_classify: combinational NaN/Inf/exceptional flags for one IEEE754 word; built only with FP_VEC_DRAIN_EXC_EN.
`ifdef FP_VEC_DRAIN_EXC_EN
module fp_classify
  import fp_vec_drain_pkg::*;
#(
  parameter int NX = 8,
  parameter int NM = 23
) (
  input  logic [fp_width(NX, NM)-1:0] word,
  output logic                        nan,
  output logic                        inf,
  output logic                        exc
);
  typedef `IEEE754(NX, NM) fp_t;
  fp_t  w_word;
  logic w_exp_ones, w_man_zero;
  assign w_word     = fp_t'(word);
  assign w_exp_ones = &w_word.exp;
  assign w_man_zero = ~|w_word.man;
  assign nan        = is_nan(w_exp_ones, w_man_zero);
  assign inf        = is_inf(w_exp_ones, w_man_zero);
  assign exc        = is_exc(w_exp_ones);
endmodule
`endif

// File: rtl/fp_vec_drain.sv
// fp_vec_drain: latches an N-word IEEE754 vector and streams it out highest index first.
// Optional NaN/Inf flag and saturating counter under macro FP_VEC_DRAIN_EXC_EN.
module fp_vec_drain
  import fp_vec_drain_pkg::*;
#(
  parameter int NX = 8,
  parameter int NM = 23,
  parameter int N  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N*fp_width(NX, NM)-1:0] in_vec,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [fp_width(NX, NM)-1:0]   out_data,
  output logic [$clog2(N)-1:0]          out_idx,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef FP_VEC_DRAIN_EXC_EN
  ,
  output logic                          out_exc,
  output logic [15:0]                   exc_cnt
`endif
);
  localparam int W  = fp_width(NX, NM);
  localparam int IW = $clog2(N);
  typedef `IEEE754(NX, NM) fp_t;
  state_t        r_state, w_next;
  fp_t           r_vec [N];
  logic [IW-1:0] r_idx;
  logic          w_accept, w_hs;
  assign w_accept = in_valid && in_ready;
  assign w_hs     = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // A new vector arriving on the final handshake keeps the drain going with no bubble.
  always_comb
    w_next = (r_state == IDLE) ? (w_accept ? DRAIN : IDLE)
           : ((w_hs && out_last && !w_accept) ? IDLE : DRAIN);
  always_comb begin
    out_valid = r_state == DRAIN;
    out_last  = out_valid && r_idx == '0;
    in_ready  = rst_n && (!out_valid || (out_ready && out_last));
    out_idx   = r_idx;
    out_data  = out_valid ? W'(r_vec[r_idx]) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx <= '0;
      r_vec <= '{default: '0};
    end else if (w_accept) begin
      r_idx <= IW'(N - 1);
      for (int k = 0; k < N; k++) r_vec[k] <= fp_t'(in_vec[k*W +: W]);
    end else if (w_hs && r_idx != '0) r_idx <= r_idx - IW'(1);
`ifdef FP_VEC_DRAIN_EXC_EN
  logic w_nan, w_inf, w_exc;
  fp_classify #(.NX(NX), .NM(NM)) u_classify (
    .word(out_data),
    .nan (w_nan),
    .inf (w_inf),
    .exc (w_exc)
  );
  assign out_exc = w_exc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) exc_cnt <= '0;
    else if (w_hs && (w_nan || w_inf) && exc_cnt != 16'hFFFF) exc_cnt <= exc_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_fp_vec_drain.sv
// tb_fp_vec_drain: table-driven and scoreboard checks of fp_vec_drain (N=4, single precision).
module tb_fp_vec_drain;
  localparam int N = 4;
  localparam int W = 32;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_vec = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_idx;
  logic           out_last;
  logic           out_valid;
  logic           out_ready = 1'b0;
`ifdef FP_VEC_DRAIN_EXC_EN
  logic           out_exc;
  logic [15:0]    exc_cnt;
`endif
  fp_vec_drain #(.NX(8), .NM(23), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vec   (in_vec),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef FP_VEC_DRAIN_EXC_EN
    ,
    .out_exc  (out_exc),
    .exc_cnt  (exc_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;
  typedef struct {
    logic        iv;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  ei;
    logic        el;
    logic        er;
  } row_t;
  exp_t q[$];
  row_t tbl[6];
  int   checks = 0;
  int   errors = 0;
  localparam logic [N*W-1:0] V  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [N*W-1:0] V2 = {32'hC1200000, 32'h00000001, 32'h7F7FFFFF, 32'h80000000};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic tick(input logic iv, input logic [N*W-1:0] v, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_vec    = v;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h required=none", out_data);
      end else begin
        e = q.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_idx", 32'(out_idx), 32'(e.idx));
        chk("sb_last", 32'(out_last), 32'(e.last));
`ifdef FP_VEC_DRAIN_EXC_EN
        chk("sb_exc", 32'(out_exc), 32'(&e.data[30:23]));
`endif
      end
    end
    if (in_valid && in_ready)
      for (int k = N - 1; k >= 0; k--) q.push_back('{v[k*W +: W], 2'(k), k == 0});
  endtask
  task automatic drain(input string name);
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, '0, 1'b1);
      if (q.size() == 0 && !out_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL %s drain_timeout queue=%0d required=0", name, q.size());
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int   first, last, cnt;
    logic acc2;
    logic pat[4];
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h40800000, 2'd3, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h40400000, 2'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h40000000, 2'd1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h3F800000, 2'd0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 1'b1};
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
`ifdef FP_VEC_DRAIN_EXC_EN
    chk("rst_out_exc", 32'(out_exc), 0);
    chk("rst_exc_cnt", 32'(exc_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      tick(tbl[i].iv, V, tbl[i].ordy);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].er));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
        chk($sformatf("tbl%0d_idx", i), 32'(out_idx), 32'(tbl[i].ei));
        chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].el));
      end
    end
    chk("tbl_queue_empty", q.size(), 0);
    tick(1'b1, V, 1'b1);
    tick(1'b0, V, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, V, 1'b0);
      chk("stall_data", out_data, 32'h40400000);
      chk("stall_idx", 32'(out_idx), 2);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    drain("stall");
    chk("stall_queue_empty", q.size(), 0);
    first = -1; last = -1; cnt = 0; acc2 = 1'b0;
    tick(1'b1, V, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      tick(!acc2, V2, 1'b1);
      if (in_valid && in_ready) acc2 = 1'b1;
      if (out_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("b2b_valid_count", cnt, 8);
    chk("b2b_contiguous", last - first + 1, 8);
    drain("b2b");
    tick(1'b1, V, 1'b1);
    tick(1'b0, V, 1'b1);
    tick(1'b0, V, 1'b1);
    tick(1'b0, V, 1'b0);
    chk("pre_rst_idx", 32'(out_idx), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_in_ready", 32'(in_ready), 0);
    chk("async_rst_idx", 32'(out_idx), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_valid", 32'(out_valid), 0);
    tick(1'b1, V, 1'b1);
    tick(1'b0, V, 1'b1);
    chk("restart_idx", 32'(out_idx), 3);
    chk("restart_data", out_data, 32'h40800000);
    drain("restart");
`ifdef FP_VEC_DRAIN_EXC_EN
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    tick(1'b1, {32'hFF800000, 32'h00000000, 32'h7F800000, 32'h7FC00000}, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, '0, 1'b1);
      chk($sformatf("exc_pat%0d", i), 32'(out_exc), 32'(pat[i]));
    end
    tick(1'b0, '0, 1'b1);
    chk("exc_cnt", 32'(exc_cnt), 3);
`endif
    for (int c = 0; c < 80; c++)
      tick(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
    drain("random");
    chk("final_queue_empty", q.size(), 0);
    chk("final_idle", 32'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
